simon_host_driver: RTL

- Initiator-side driver for the SIMON block-cipher core handshake (newKey/ldKey/doneKey, newData/ldData/doneData/readData).
- Accepts a narrow word stream from the system side and assembles full keys (M*N bits) and blocks (2*N bits).
- Pushes them into the core, collects the result and returns it as a word stream.
- Sits between a system bus/FIFO and one SIMON core instance; default sizing targets SIMON 128/256.

---
 rtl/simon_host_driver.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/simon_host_driver.sv
// Stream-to-handshake driver for one SIMON core: assembles keys/blocks from W-bit words,
// runs the newKey/newData handshakes and streams the result back. Optional watchdog: SIMON_DRV_TIMEOUT_EN.
module simon_host_driver #(
   parameter int N         = 64,
   parameter int M         = 4,
   parameter int W         = 32,
   parameter int TO_CYCLES = 1023
) (
   input  logic             clk,
   input  logic             nR,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_is_key,
   input  logic             in_enc_dec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic             err_nokey,
   output logic             err_timeout,
   output logic             newKey,
   output logic             newData,
   output logic             enc_dec,
   output logic             readData,
   output logic [2*N-1:0]   plain,
   output logic [M*N-1:0]   key,
   input  logic             ldKey,
   input  logic             ldData,
   input  logic             doneKey,
   input  logic             doneData,
   input  logic [2*N-1:0]   cipher
);

   localparam int AW = M*N;
   localparam int BW = 2*N;
   localparam int KW = AW/W;
   localparam int DW = BW/W;
   localparam int CW = $clog2(KW+1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_COLLECT   = 3'd1;
   localparam logic [2:0] S_SEND_KEY  = 3'd2;
   localparam logic [2:0] S_WAIT_KEY  = 3'd3;
   localparam logic [2:0] S_SEND_DATA = 3'd4;
   localparam logic [2:0] S_WAIT_DATA = 3'd5;
   localparam logic [2:0] S_DRAIN     = 3'd6;

   if ((BW % W) != 0 || (AW % W) != 0 || M < 2 || TO_CYCLES < 1) begin : g_bad_cfg
      $error("simon_host_driver: invalid parameter set");
   end

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, nxt;
   logic          is_key_q, is_key_d, dir_q, dir_d;
   logic [AW-1:0] asm_q, asm_d, key_q, key_d;
   logic [BW-1:0] plain_q, plain_d, result_q, result_d;
   logic          key_loaded_q, key_loaded_d;
   logic          enc_dec_q, enc_dec_d, newKey_q, newKey_d, newData_q, newData_d;
   logic          readData_q, readData_d, in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          err_nokey_q, err_nokey_d, err_to_q, err_to_d;
   logic          frame_done, frame_key, frame_dir;

`ifdef SIMON_DRV_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYCLES+1);
   logic [TW-1:0] to_q, to_d;
   logic          timed;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      is_key_d     = is_key_q;
      dir_d        = dir_q;
      asm_d        = asm_q;
      key_d        = key_q;
      plain_d      = plain_q;
      result_d     = result_q;
      key_loaded_d = key_loaded_q;
      enc_dec_d    = enc_dec_q;
      newKey_d     = newKey_q;
      newData_d    = newData_q;
      readData_d   = 1'b0;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      err_nokey_d  = 1'b0;
      err_to_d     = 1'b0;
      frame_done   = 1'b0;
      frame_key    = is_key_q;
      frame_dir    = dir_q;
      nxt          = CW'(cnt_q + 1'b1);

      case (state_q)
         S_IDLE: if (in_valid && in_ready_q) begin
            is_key_d   = in_is_key;
            dir_d      = in_enc_dec;
            frame_key  = in_is_key;
            frame_dir  = in_enc_dec;
            asm_d[W-1:0] = in_data;
            cnt_d      = CW'(1);
            state_d    = S_COLLECT;
            frame_done = ((in_is_key ? KW : DW) == 1);
         end
         S_COLLECT: if (in_valid && in_ready_q) begin
            for (int unsigned i = 1; i < KW; i++)
               if (cnt_q == CW'(i)) asm_d[i*W +: W] = in_data;
            cnt_d      = nxt;
            frame_done = (cnt_q == CW'((is_key_q ? KW : DW) - 1));
         end
         S_SEND_KEY: if (newKey_q && ldKey) begin
            newKey_d = 1'b0;
            state_d  = S_WAIT_KEY;
         end
         S_WAIT_KEY: if (doneKey) begin
            key_loaded_d = 1'b1;
            state_d      = S_IDLE;
         end
         S_SEND_DATA: if (newData_q && ldData) begin
            newData_d = 1'b0;
            state_d   = S_WAIT_DATA;
         end
         S_WAIT_DATA: if (doneData) begin
            result_d   = cipher;
            readData_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_DRAIN;
         end
         S_DRAIN: begin
            // first DRAIN cycle only loads word 0, giving the 2-cycle doneData-to-data latency
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = result_q[W-1:0];
               out_last_d  = (DW == 1);
            end else if (out_ready) begin
               if (cnt_q == CW'(DW-1)) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  cnt_d       = '0;
                  state_d     = S_IDLE;
               end else begin
                  cnt_d      = nxt;
                  out_last_d = (nxt == CW'(DW-1));
                  for (int unsigned i = 0; i < DW; i++)
                     if (nxt == CW'(i)) out_data_d = result_q[i*W +: W];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (frame_done) begin
         cnt_d = '0;
         if (frame_key) begin
            key_d        = asm_d;
            key_loaded_d = 1'b0;
            newKey_d     = 1'b1;
            state_d      = S_SEND_KEY;
         end else if (key_loaded_q) begin
            plain_d   = asm_d[BW-1:0];
            enc_dec_d = frame_dir;
            newData_d = 1'b1;
            state_d   = S_SEND_DATA;
         end else begin
            err_nokey_d = 1'b1;
            state_d     = S_IDLE;
         end
      end

`ifdef SIMON_DRV_TIMEOUT_EN
      timed = (state_q == S_SEND_KEY) || (state_q == S_WAIT_KEY) ||
              (state_q == S_SEND_DATA) || (state_q == S_WAIT_DATA);
      to_d  = (timed && state_d == state_q) ? TW'(to_q + 1'b1) : '0;
      if (timed && to_q == TW'(TO_CYCLES-1)) begin
         newKey_d     = 1'b0;
         newData_d    = 1'b0;
         readData_d   = 1'b0;
         err_to_d     = 1'b1;
         key_loaded_d = 1'b0;
         state_d      = S_IDLE;
         to_d         = '0;
      end
`endif

      in_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
   end

   always_ff @(posedge clk) begin
      if (!nR) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         is_key_q     <= 1'b0;
         dir_q        <= 1'b0;
         asm_q        <= '0;
         key_q        <= '0;
         plain_q      <= '0;
         result_q     <= '0;
         key_loaded_q <= 1'b0;
         enc_dec_q    <= 1'b0;
         newKey_q     <= 1'b0;
         newData_q    <= 1'b0;
         readData_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         err_nokey_q  <= 1'b0;
         err_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_key_q     <= is_key_d;
         dir_q        <= dir_d;
         asm_q        <= asm_d;
         key_q        <= key_d;
         plain_q      <= plain_d;
         result_q     <= result_d;
         key_loaded_q <= key_loaded_d;
         enc_dec_q    <= enc_dec_d;
         newKey_q     <= newKey_d;
         newData_q    <= newData_d;
         readData_q   <= readData_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         err_nokey_q  <= err_nokey_d;
         err_to_q     <= err_to_d;
      end
   end

`ifdef SIMON_DRV_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!nR) to_q <= '0;
      else     to_q <= to_d;
   end
   assign err_timeout = err_to_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign err_nokey = err_nokey_q;
   assign newKey    = newKey_q;
   assign newData   = newData_q;
   assign enc_dec   = enc_dec_q;
   assign readData  = readData_q;
   assign plain     = plain_q;
   assign key       = key_q;

endmodule
